// File: rtl/vga_timing_gen.sv
// VGA raster timing in the boardCLK domain. vgaCLK is edge-detected as data to form pixelTick.
// Optional tick watchdog (tickError output) is built when VGA_TICK_WATCHDOG_EN is defined.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic       boardCLK,
  input  logic       reset,
  input  logic       vgaCLK,
  input  logic       enable,
  output logic       pixelTick,
  output logic       hsync,
  output logic       vsync,
  output logic       videoOn,
  output logic [9:0] pixelX,
  output logic [9:0] pixelY,
  output logic       frameStart
`ifdef VGA_TICK_WATCHDOG_EN
  ,
  output logic       tickError
`endif
);

  localparam int unsigned CW       = 10;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC - 1;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC - 1;

  logic          vga_prev;
  logic          advance;
  logic          x_last;
  logic          y_last;
  logic [CW-1:0] x_nxt;
  logic [CW-1:0] y_nxt;
  logic          hs_on;
  logic          vs_on;
  logic          vid_on;

  // Next-state counters and decode, so registered syncs line up with the counters
  always_comb begin
    advance = pixelTick & enable;
    x_last  = (pixelX == CW'(H_TOTAL - 1));
    y_last  = (pixelY == CW'(V_TOTAL - 1));
    x_nxt   = x_last ? '0 : pixelX + CW'(1);
    y_nxt   = pixelY;
    if (x_last) begin
      y_nxt = y_last ? '0 : pixelY + CW'(1);
    end
    hs_on  = (x_nxt >= CW'(HS_START)) && (x_nxt <= CW'(HS_END));
    vs_on  = (y_nxt >= CW'(VS_START)) && (y_nxt <= CW'(VS_END));
    vid_on = (x_nxt < CW'(H_ACTIVE)) && (y_nxt < CW'(V_ACTIVE));
  end

  // vga_prev resets high so a vgaCLK already high at release is not an edge
  always_ff @(posedge boardCLK or negedge reset) begin
    if (!reset) begin
      vga_prev   <= 1'b1;
      pixelTick  <= 1'b0;
      pixelX     <= '0;
      pixelY     <= '0;
      hsync      <= ~SYNC_POL;
      vsync      <= ~SYNC_POL;
      videoOn    <= 1'b0;
      frameStart <= 1'b0;
    end else begin
      vga_prev   <= vgaCLK;
      pixelTick  <= vgaCLK & ~vga_prev;
      frameStart <= 1'b0;
      if (advance) begin
        pixelX     <= x_nxt;
        pixelY     <= y_nxt;
        hsync      <= hs_on ? SYNC_POL : ~SYNC_POL;
        vsync      <= vs_on ? SYNC_POL : ~SYNC_POL;
        videoOn    <= vid_on;
        frameStart <= x_last & y_last;
      end
    end
  end

`ifdef VGA_TICK_WATCHDOG_EN
  localparam int unsigned GAP_W    = 8;
  localparam int unsigned GAP_LIMIT = 16;

  logic [GAP_W-1:0] gap_cnt;

  // Gap counter saturates so a stalled divider cannot wrap back under the limit
  always_ff @(posedge boardCLK or negedge reset) begin
    if (!reset) begin
      gap_cnt   <= '0;
      tickError <= 1'b0;
    end else begin
      if (pixelTick) begin
        gap_cnt <= '0;
      end else if (gap_cnt != {GAP_W{1'b1}}) begin
        gap_cnt <= gap_cnt + GAP_W'(1);
      end
      if (enable && (gap_cnt >= GAP_W'(GAP_LIMIT))) begin
        tickError <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 instance for horizontal timing, a tiny-geometry
// active-high-sync instance for vertical/frame wrap within a short run.
module tb_vga_timing_gen;

  logic       boardCLK;
  logic       reset;
  logic       vgaCLK;
  logic       enable;

  logic       b_tick, b_hs, b_vs, b_von, b_fs;
  logic [9:0] b_x, b_y;
  logic       s_tick, s_hs, s_vs, s_von, s_fs;
  logic [9:0] s_x, s_y;
`ifdef VGA_TICK_WATCHDOG_EN
  logic       b_terr, s_terr;
`endif

  int errors = 0;
  int checks = 0;
  int ph     = 0;
  int tk     = 0;
  logic run_en   = 1'b0;
  logic hold_val = 1'b0;

  vga_timing_gen u_big (
    .boardCLK  (boardCLK),
    .reset     (reset),
    .vgaCLK    (vgaCLK),
    .enable    (enable),
    .pixelTick (b_tick),
    .hsync     (b_hs),
    .vsync     (b_vs),
    .videoOn   (b_von),
    .pixelX    (b_x),
    .pixelY    (b_y),
    .frameStart(b_fs)
`ifdef VGA_TICK_WATCHDOG_EN
    ,
    .tickError (b_terr)
`endif
  );

  // H_TOTAL=16 (hsync x 10..12), V_TOTAL=10 (vsync y 7..8), syncs active-high
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b1)
  ) u_small (
    .boardCLK  (boardCLK),
    .reset     (reset),
    .vgaCLK    (vgaCLK),
    .enable    (enable),
    .pixelTick (s_tick),
    .hsync     (s_hs),
    .vsync     (s_vs),
    .videoOn   (s_von),
    .pixelX    (s_x),
    .pixelY    (s_y),
    .frameStart(s_fs)
`ifdef VGA_TICK_WATCHDOG_EN
    ,
    .tickError (s_terr)
`endif
  );

  initial boardCLK = 1'b0;
  always #5 boardCLK = ~boardCLK;

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check10(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One boardCLK per iteration; a running vgaCLK is 0,0,1,1 as sampled by the DUT
  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      vgaCLK = run_en ? (ph >= 2) : hold_val;
      ph = (ph + 1) % 4;
      @(posedge boardCLK);
      #1;
    end
  endtask

  // Advance to a given count of enabled ticks since reset, 4 cycles per tick
  task automatic adv_to(input int target);
    cycles(4 * (target - tk));
    tk = target;
  endtask

  initial begin
    reset  = 1'b0;
    enable = 1'b1;
    vgaCLK = 1'b0;
    cycles(3);
    check10("rst_x", b_x, 10'd0);
    check10("rst_y", b_y, 10'd0);
    check1("rst_hsync", b_hs, 1'b1);
    check1("rst_vsync", b_vs, 1'b1);
    check1("rst_video", b_von, 1'b0);
    check1("rst_tick", b_tick, 1'b0);
    check1("rst_frame", b_fs, 1'b0);
    check1("rst_s_hsync", s_hs, 1'b0);
    check1("rst_s_vsync", s_vs, 1'b0);
`ifdef VGA_TICK_WATCHDOG_EN
    check1("rst_terr", b_terr, 1'b0);
`endif

    // Release and check the 4-cycle tick cadence
    reset  = 1'b1;
    ph     = 0;
    run_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycles(1);
      check1("tick_period", b_tick, (i % 4) == 2);
    end
    tk = 2;
    check10("x_after_2", b_x, 10'd2);

    // Vertical sync and frame wrap on the small instance
    adv_to(111);
    check10("s_x_111", s_x, 10'd15);
    check10("s_y_111", s_y, 10'd6);
    check1("s_vsync_y6", s_vs, 1'b0);
    adv_to(112);
    check10("s_y_112", s_y, 10'd7);
    check1("s_vsync_y7", s_vs, 1'b1);
    check1("s_video_y7", s_von, 1'b0);
    adv_to(143);
    check10("s_y_143", s_y, 10'd8);
    check1("s_vsync_y8", s_vs, 1'b1);
    adv_to(144);
    check10("s_y_144", s_y, 10'd9);
    check1("s_vsync_y9", s_vs, 1'b0);
    adv_to(159);
    check10("s_x_159", s_x, 10'd15);
    check1("s_frame_159", s_fs, 1'b0);
    adv_to(160);
    check10("s_x_wrap", s_x, 10'd0);
    check10("s_y_wrap", s_y, 10'd0);
    check1("s_frame_wrap", s_fs, 1'b1);
    check1("s_video_00", s_von, 1'b1);
    check1("b_frame_160", b_fs, 1'b0);
    check10("b_x_160", b_x, 10'd160);
    cycles(1);
    check1("s_frame_width", s_fs, 1'b0);
    cycles(3);
    tk = 161;

    // Small-instance horizontal decode
    adv_to(167);
    check1("s_video_x7", s_von, 1'b1);
    check1("s_hsync_x7", s_hs, 1'b0);
    adv_to(169);
    check1("s_video_x9", s_von, 1'b0);
    check1("s_hsync_x9", s_hs, 1'b0);
    adv_to(170);
    check1("s_hsync_x10", s_hs, 1'b1);
    adv_to(172);
    check1("s_hsync_x12", s_hs, 1'b1);
    adv_to(173);
    check1("s_hsync_x13", s_hs, 1'b0);

    // Default-geometry horizontal boundaries
    adv_to(639);
    check10("b_x_639", b_x, 10'd639);
    check1("b_video_639", b_von, 1'b1);
    check1("b_hsync_639", b_hs, 1'b1);
    adv_to(640);
    check1("b_video_640", b_von, 1'b0);
    adv_to(655);
    check1("b_hsync_655", b_hs, 1'b1);
    adv_to(656);
    check1("b_hsync_656", b_hs, 1'b0);
    adv_to(751);
    check1("b_hsync_751", b_hs, 1'b0);
    adv_to(752);
    check1("b_hsync_752", b_hs, 1'b1);
    adv_to(799);
    check10("b_x_799", b_x, 10'd799);
    check10("b_y_799", b_y, 10'd0);
    adv_to(800);
    check10("b_x_wrap", b_x, 10'd0);
    check10("b_y_line1", b_y, 10'd1);
    check1("b_frame_line1", b_fs, 1'b0);
    check1("b_video_line1", b_von, 1'b1);

    // Enable drop at x=300 for 40 cycles
    adv_to(1100);
    check10("b_x_300", b_x, 10'd300);
    enable = 1'b0;
    for (int g = 0; g < 10; g++) begin
      cycles(3);
      check1("tick_while_disabled", b_tick, 1'b1);
      cycles(1);
    end
    check10("b_x_hold", b_x, 10'd300);
    check10("b_y_hold", b_y, 10'd1);
    check1("b_video_hold", b_von, 1'b1);
    enable = 1'b1;
    cycles(4);
    tk = 1101;
    check10("b_x_resume", b_x, 10'd301);

    // Reset mid-line with vgaCLK held high
    cycles(3);
    check1("tick_before_rst", b_tick, 1'b1);
    run_en   = 1'b0;
    hold_val = 1'b1;
    cycles(1);
    check10("b_x_before_rst", b_x, 10'd302);
    reset = 1'b0;
    #1;
    check10("async_rst_x", b_x, 10'd0);
    check10("async_rst_y", b_y, 10'd0);
    check1("async_rst_video", b_von, 1'b0);
    check1("async_rst_hsync", b_hs, 1'b1);
    check1("async_rst_tick", b_tick, 1'b0);
    check1("async_rst_s_vsync", s_vs, 1'b0);
    @(posedge boardCLK);
    #1;
    cycles(1);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycles(1);
      check1("no_tick_high_release", b_tick, 1'b0);
    end
    check10("b_x_after_release", b_x, 10'd0);
    ph     = 0;
    run_en = 1'b1;
    cycles(3);
    check1("first_tick_after_rst", b_tick, 1'b1);
    cycles(1);
    check10("b_x_first", b_x, 10'd1);
    check10("b_y_first", b_y, 10'd0);
    check1("b_video_first", b_von, 1'b1);

`ifdef VGA_TICK_WATCHDOG_EN
    // Stalled vgaCLK: error after a 16-cycle gap, sticky afterwards
    check1("terr_nominal", b_terr, 1'b0);
    run_en   = 1'b0;
    hold_val = 1'b0;
    cycles(15);
    check1("terr_gap15", b_terr, 1'b0);
    cycles(5);
    check1("terr_gap20", b_terr, 1'b1);
    check1("s_terr_gap20", s_terr, 1'b1);
    ph     = 0;
    run_en = 1'b1;
    cycles(8);
    check1("terr_sticky", b_terr, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Consumes the divided 25 MHz pixel clock signal `vgaCLK` and turns it into a pixel-rate enable strobe in the 100 MHz `boardCLK` domain. Drives the 640x480@60 Hz VGA horizontal/vertical counters, sync pulses, active-video flag and frame-start strobe. Sits between the clock divider and the pixel/renderer logic. All logic is clocked by `boardCLK`; `vgaCLK` is sampled as data and never used as a clock.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `SYNC_POL`, 0, asserted level of hsync/vsync (0 = active-low)

Ports:
- `boardCLK` in 1 — 100 MHz system clock; the only clock
- `reset` in 1 — asynchronous, active-low reset
- `vgaCLK` in 1 — divided pixel clock from the divider, sampled as data
- `enable` in 1 — high: timing runs; low: counters and outputs freeze
- `pixelTick` out 1 — one-`boardCLK` pulse per detected `vgaCLK` rising edge
- `hsync` out 1 — horizontal sync, level per `SYNC_POL`
- `vsync` out 1 — vertical sync, level per `SYNC_POL`
- `videoOn` out 1 — high while (x,y) is inside the active area
- `pixelX` out 10 — current horizontal count, 0..H_TOTAL-1
- `pixelY` out 10 — current vertical count, 0..V_TOTAL-1
- `frameStart` out 1 — one-cycle pulse when counters advance to (0,0)

## Operation
- H_TOTAL = sum of H params (800); V_TOTAL = sum of V params (525).
- Edge detect: `vgaPrev` register holds `vgaCLK` delayed by one cycle. `pixelTick` = registered (`vgaCLK` & ~`vgaPrev`). Nominally it fires every 4th `boardCLK` cycle.
- On `pixelTick` with `enable`=1:
  - `pixelX` increments.
  - At H_TOTAL-1, `pixelX` wraps to 0 and `pixelY` increments.
  - At V_TOTAL-1, `pixelY` also wraps to 0.
- Sync and active-video decode, from next-state counters and registered so they align with `pixelX`/`pixelY`:
  - `hsync` asserted iff x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [656,751].
  - `vsync` asserted iff y in [490,491].
  - `videoOn` = (x < H_ACTIVE) & (y < V_ACTIVE).
- `frameStart`: pulses in the same cycle the counters become (0,0) through wrap. Never pulses on reset release.
- `enable`=0:
  - Ticks are ignored for counting.
  - `pixelTick` is still generated.
  - All other outputs hold their values.
- Reset (any time, including mid-frame) immediately forces:
  - `pixelX`=0, `pixelY`=0
  - `hsync`=`vsync`=~SYNC_POL
  - `videoOn`=0, `pixelTick`=0, `frameStart`=0
  - `vgaPrev`=1, so a `vgaCLK` that is high at release does not count as an edge.
- `videoOn` becomes valid after the first enabled tick.

## Timing
- `vgaCLK` rise at cycle n → `pixelTick` high at cycle n+1 → counters/syncs update at cycle n+2.
- `pixelTick` is exactly one cycle wide. Consecutive ticks are at least 2 cycles apart, because the input must fall in between.
- Line = 800 ticks = 3200 `boardCLK` cycles. Frame = 525 lines = 1,680,000 cycles.
- Simultaneous horizontal and vertical wrap at (799,524): both wrap in one cycle and `frameStart` pulses.

## Configuration
- `VGA_TICK_WATCHDOG_EN` defined:
  - Adds output `tickError` (1 bit, reset 0).
  - An 8-bit gap counter clears on every `pixelTick` and increments otherwise.
  - `tickError` becomes sticky-high if the count reaches 16 while `enable`=1.
  - `tickError` is cleared only by reset.
- Not defined: no port, no counter, no logic.

## Test plan
- Reset then run a free-running 4-cycle `vgaCLK` with `enable`=1:
  - `pixelTick` period is 4 cycles.
  - `pixelX` counts 0..799 and wraps.
  - `pixelY` increments once per 3200 cycles.
- Horizontal sync:
  - `hsync`=0 exactly for x 656..751 (96 ticks).
  - `videoOn`=1 for x 0..639 and 0 at x 640.
- Full frame:
  - `vsync` low for y 490..491.
  - `frameStart` pulses once per 1,680,000 cycles, coincident with (0,0).
- Mid-line at x=300: drop `enable` for 40 cycles, then restore. `pixelX` holds 300, then resumes at 301.
- Reset mid-frame at (400,250) with `vgaCLK` high:
  - Outputs go immediately to reset values.
  - After release, no tick until the next `vgaCLK` rising edge.
- With `VGA_TICK_WATCHDOG_EN`: hold `vgaCLK` low for 20 cycles with `enable`=1. `tickError` rises at gap 16 and stays 1 after ticks resume.
